weight_seq_ctrl: RTL

Per-layer sequencer for weight_manager. It accepts a layer descriptor (cin, cout) and streams cin*cout 72-bit weight words from the DMA into weight_manager in write mode. It then waits for write_complete, and on compute_start runs one continuous group read. Each read group is tagged with (ci_group, co_group) indices for the conv engine. Sits between the layer scheduler/DMA and weight_manager.

---
 rtl/weight_seq_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/weight_seq_ctrl.sv
// Per-layer sequencer for weight_manager: streams a layer's weights in write mode,
// then replays them as one continuous group read tagged with (ci, co) indices.
`timescale 1ns/1ps
module weight_seq_ctrl #(
   parameter int MAX_GROUPS = 512,
   parameter int WC_TIMEOUT = 1024,
   parameter int DATA_W     = 72
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [11:0]       cfg_cin,
   input  logic [11:0]       cfg_cout,
   input  logic              abort,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              wm_write_mode,
   output logic              wm_data_valid,
   output logic [DATA_W-1:0] wm_data_in,
   input  logic              wm_write_complete,
   output logic [9:0]        wm_cfg_ci_groups,
   output logic [9:0]        wm_cfg_co_groups,
   output logic              wm_read_en,
   input  logic              wm_data_ready,
   input  logic              wm_read_complete,
   input  logic              compute_start,
   output logic              grp_valid,
   output logic [9:0]        grp_ci_idx,
   output logic [9:0]        grp_co_idx,
   output logic              grp_last_ci,
   output logic              grp_last,
   output logic              loaded,
   output logic              busy,
   output logic              layer_done,
   output logic              error
);

   localparam int TW = $clog2(WC_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT_WC, S_ARMED, S_READ, S_WAIT_RC, S_DONE
   } state_t;

   state_t              state_q;
   logic [9:0]          ci_groups_q, co_groups_q;
   logic [16:0]         total_words_q, wcnt_q;
   logic [TW-1:0]       tcnt_q;
   logic [9:0]          ci_cnt_q, co_cnt_q;
   logic                wr_mode_q, rd_en_q, err_q;
   logic                vld_p1;
   logic [DATA_W-1:0]   data_p1;

   logic [8:0]  cig, cog;
   logic [17:0] grp_prod;
   logic        accept, last_ci, last_co, timeout, in_read;

   function automatic logic cfg_legal(input logic [11:0] cin, input logic [11:0] cout,
                                      input logic [17:0] groups);
      return (cin != 12'd0) && (cin[2:0] == 3'd0) &&
             (cout != 12'd0) && (cout[2:0] == 3'd0) &&
             (groups <= 18'(MAX_GROUPS));
   endfunction

   assign cig      = cfg_cin[11:3];
   assign cog      = cfg_cout[11:3];
   assign grp_prod = {9'd0, cig} * {9'd0, cog};

   assign in_read  = (state_q == S_READ);
   assign s_ready  = (state_q == S_LOAD) && (wcnt_q < total_words_q);
   assign accept   = s_valid && s_ready;
   assign last_ci  = (ci_cnt_q == ci_groups_q - 10'd1);
   assign last_co  = (co_cnt_q == co_groups_q - 10'd1);
   assign timeout  = (tcnt_q == TW'(WC_TIMEOUT - 1));

   assign cfg_ready        = (state_q == S_IDLE);
   assign loaded           = (state_q == S_ARMED);
   assign busy             = (state_q != S_IDLE);
   assign layer_done       = (state_q == S_DONE);
   assign error            = err_q;
   assign wm_write_mode    = wr_mode_q;
   assign wm_read_en       = rd_en_q;
   assign wm_data_valid    = vld_p1;
   assign wm_data_in       = data_p1;
   assign wm_cfg_ci_groups = ci_groups_q;
   assign wm_cfg_co_groups = co_groups_q;
   assign grp_valid        = in_read && wm_data_ready;
   assign grp_ci_idx       = ci_cnt_q;
   assign grp_co_idx       = co_cnt_q;
   assign grp_last_ci      = grp_valid && last_ci;
   assign grp_last         = grp_valid && last_ci && last_co;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         ci_groups_q   <= '0;
         co_groups_q   <= '0;
         total_words_q <= '0;
         wcnt_q        <= '0;
         tcnt_q        <= '0;
         ci_cnt_q      <= '0;
         co_cnt_q      <= '0;
         wr_mode_q     <= 1'b0;
         rd_en_q       <= 1'b0;
         err_q         <= 1'b0;
         vld_p1        <= 1'b0;
         data_p1       <= '0;
      end else begin
         err_q  <= 1'b0;
         vld_p1 <= 1'b0;
         if (abort) begin
            state_q   <= S_IDLE;
            wr_mode_q <= 1'b0;
            rd_en_q   <= 1'b0;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
            ci_cnt_q  <= '0;
            co_cnt_q  <= '0;
         end else begin
            case (state_q)
               S_IDLE: if (cfg_valid) begin
                  if (cfg_legal(cfg_cin, cfg_cout, grp_prod)) begin
                     ci_groups_q   <= {1'b0, cig};
                     co_groups_q   <= {1'b0, cog};
                     // groups*64 == cin*cout once both are multiples of 8
                     total_words_q <= {grp_prod[10:0], 6'd0};
                     wcnt_q        <= '0;
                     wr_mode_q     <= 1'b1;
                     state_q       <= S_LOAD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               // stage p0 -> p1: accepted DMA word becomes next cycle's write beat
               S_LOAD: if (accept) begin
                  data_p1 <= s_data;
                  vld_p1  <= 1'b1;
                  wcnt_q  <= wcnt_q + 17'd1;
                  if (wcnt_q + 17'd1 == total_words_q) begin
                     tcnt_q  <= '0;
                     state_q <= S_WAIT_WC;
                  end
               end
               S_WAIT_WC: begin
                  if (wm_write_complete) begin
                     state_q <= S_ARMED;
                  end else if (timeout) begin
                     err_q     <= 1'b1;
                     wr_mode_q <= 1'b0;
                     state_q   <= S_IDLE;
                  end else begin
                     tcnt_q <= tcnt_q + TW'(1);
                  end
               end
               S_ARMED: begin
                  wr_mode_q <= 1'b0;
                  ci_cnt_q  <= '0;
                  co_cnt_q  <= '0;
                  if (compute_start) begin
                     rd_en_q <= 1'b1;
                     state_q <= S_READ;
                  end
               end
               S_READ: if (wm_data_ready) begin
                  if (last_ci && last_co) begin
                     rd_en_q  <= 1'b0;
                     ci_cnt_q <= '0;
                     co_cnt_q <= '0;
                     tcnt_q   <= '0;
                     state_q  <= wm_read_complete ? S_DONE : S_WAIT_RC;
                  end else if (last_ci) begin
                     ci_cnt_q <= '0;
                     co_cnt_q <= co_cnt_q + 10'd1;
                  end else begin
                     ci_cnt_q <= ci_cnt_q + 10'd1;
                  end
               end
               S_WAIT_RC: begin
                  if (wm_read_complete) begin
                     state_q <= S_DONE;
                  end else if (timeout) begin
                     err_q   <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     tcnt_q <= tcnt_q + TW'(1);
                  end
               end
               S_DONE:  state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule
